lfu_counter_bank: RTL and testbench
===================================

// Module: lfu_counter_bank
// PURPOSE
//  Owns the per-set, per-way LFU use counters of the 4-way cache and feeds them to the LFU victim comparator.
//  Increments a way's counter on hit, reseeds it on fill, ages the whole set on saturation, and bulk-clears on flush.
//  Sits between the cache controller (hit/fill events) and the victim-select comparator (count0..count3 consumer).
// PARAMETERS
//  sizeCounter  4   width of each LFU counter (max value CMAX = 2**sizeCounter-1)
//  numSets      16  number of cache sets (power of two, >=2); SET_W = $clog2(numSets)
// PORTS
//  clk         in   1            single clock, rising edge
//  rst         in   1            asynchronous reset, active-high
//  hit_valid   in   1            cache hit event this cycle
//  hit_set     in   SET_W        set index of hit
//  hit_way     in   2            way index of hit
//  fill_valid  in   1            line fill (replacement) event this cycle
//  fill_set    in   SET_W        set index of fill
//  fill_way    in   2            way being filled
//  rd_valid    in   1            request counters of rd_set
//  rd_set      in   SET_W        set index to read
//  flush       in   1            start bulk clear of all counters (pulse)
//  busy        out  1            flush in progress; all events and reads ignored
//  cnt_valid   out  1            count0..count3 valid this cycle
//  count0..3   out  sizeCounter  counters of ways 0..3 of the read set (to comparator)
// BEHAVIOUR
//  - Reset (async): every counter 0, FSM=IDLE, busy=0, cnt_valid=0, count0..3=0.
//  - FSM states: IDLE, FLUSH. IDLE->FLUSH on flush=1 (busy=1 from next cycle). FLUSH clears one set per
//    cycle, index 0..numSets-1 via flush_idx; after set numSets-1 -> IDLE, busy=0. Flush lasts exactly numSets cycles.
//  - flush asserted while busy: ignored (no restart). flush has priority over same-cycle hit/fill/read (all dropped).
//  - In IDLE, hit: counter[set][way] += 1, saturating rule below. Fill: counter[set][way] <= 1 (new line counts as one use).
//  - Saturation/aging: hit on a counter already at CMAX -> every way in that set shifts right by 1, then hit way
//    becomes (CMAX>>1)+1. Other sets unaffected. No counter ever wraps to 0.
//  - Hit and fill same cycle, same set and way: fill wins (result 1). Same set, different ways: both applied;
//    if the hit triggers aging, the filled way still ends at 1 (fill applied after aging).
//  - Different sets: both applied independently.
//  - Read: rd_valid in IDLE -> next cycle cnt_valid=1 and count0..3 = counters of rd_set *including* updates
//    made in the request cycle (write-first). Latency 1 cycle, one read per cycle, fully pipelined.
//  - cnt_valid is 0 whenever no read was accepted the previous cycle; count0..3 hold last value when cnt_valid=0.
//  - Reads requested while busy: dropped, cnt_valid=0 next cycle.
//  - Indices are all in range by construction (numSets power of two); no bounds checks.
// STRUCTURE
//  - Package lfu_pkg: NUM_WAYS=4, way_t (logic [1:0]), count_t (logic [sizeCounter-1:0]),
//    set_counts_t (count_t [NUM_WAYS-1:0]), state_t enum {IDLE, FLUSH}, function sat_inc.
//  - Sub-module lfu_set_update (combinational): inputs current set_counts_t, hit_en/hit_way, fill_en/fill_way;
//    output next set_counts_t implementing increment, aging and fill priority. Instantiated twice (hit set, fill set),
//    merged when sets match.
//  - Counter array in flops (numSets x 4 x sizeCounter), async-reset; FSM and flush_idx in top.
// TESTING
//  - Reset mid-flush (cycle 5 of 16) -> all counters 0, busy=0 immediately, IDLE; read set 3 -> counts 0,0,0,0.
//  - Fill set 2 way 1, then 3 hits way 1 -> read set 2 gives count1=4, others 0, cnt_valid one cycle after rd_valid.
//  - Set 5 counts {3,6,15,8}, hit way 2 -> {1,3,8,4}; further hit way 2 -> {1,3,9,4}.
//  - Same cycle hit+fill set 7 way 0 (count 9) -> count0=1; hit way 0 + fill way 3 on set 7 {4,2,2,2} -> {5,2,2,1}.
//  - Hit set 1 way 3 and rd_valid set 1 same cycle, count3 was 2 -> next cycle count3=3 (write-first).
//  - flush pulse with numSets=16 -> busy high 16 cycles; hits/reads during busy dropped; all counters 0 after.

Source files
------------

// File: rtl/lfu_pkg.sv
`default_nettype none
// ============================================================================
// lfu_pkg : shared types and helpers for the LFU counter bank
// Revision: 1.0 - initial release
// ============================================================================
package lfu_pkg;

  localparam int COUNT_W  = 4;
  localparam int NUM_WAYS = 4;
  localparam logic [COUNT_W-1:0] CMAX = '1;

  typedef logic [1:0]                 way_t;
  typedef logic [COUNT_W-1:0]         count_t;
  typedef count_t [NUM_WAYS-1:0]      set_counts_t;
  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  // A saturated counter restarts just above half range once its set is aged.
  function automatic count_t sat_inc(input count_t c);
    if (c == CMAX) return count_t'((CMAX >> 1) + 1);
    else           return count_t'(c + 1'b1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfu_set_update.sv
`default_nettype none
// ============================================================================
// lfu_set_update : next-value logic for the four counters of one set
// Revision: 1.0 - initial release
// ============================================================================
module lfu_set_update
  import lfu_pkg::*;
(
  input  set_counts_t cur,
  input  logic        hit_en,
  input  way_t        hit_way,
  input  logic        fill_en,
  input  way_t        fill_way,
  output set_counts_t nxt
);

  always_comb begin
    nxt = cur;
    if (hit_en) begin
      if (cur[hit_way] == CMAX) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          nxt[w] = cur[w] >> 1;
        end
      end
      nxt[hit_way] = sat_inc(cur[hit_way]);
    end
    // Fill is applied last so it overrides both the hit and any aging.
    if (fill_en) begin
      nxt[fill_way] = count_t'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lfu_counter_bank.sv
`default_nettype none
// ============================================================================
// lfu_counter_bank : per-set/per-way LFU use counters with flush and read port
// Revision: 1.0 - initial release
// ============================================================================
module lfu_counter_bank
  import lfu_pkg::*;
#(
  parameter  int sizeCounter = COUNT_W,  // must match the package counter width
  parameter  int numSets     = 16,
  localparam int SET_W       = $clog2(numSets)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hit_valid,
  input  logic [SET_W-1:0]       hit_set,
  input  logic [1:0]             hit_way,
  input  logic                   fill_valid,
  input  logic [SET_W-1:0]       fill_set,
  input  logic [1:0]             fill_way,
  input  logic                   rd_valid,
  input  logic [SET_W-1:0]       rd_set,
  input  logic                   flush,
  output logic                   busy,
  output logic                   cnt_valid,
  output logic [sizeCounter-1:0] count0,
  output logic [sizeCounter-1:0] count1,
  output logic [sizeCounter-1:0] count2,
  output logic [sizeCounter-1:0] count3
);

  state_t           r_state, w_state_next;
  logic [SET_W-1:0] r_flush_idx;
  set_counts_t      r_counts [numSets];
  set_counts_t      r_rd_counts;
  logic             r_cnt_valid;

  set_counts_t w_hit_next, w_fill_next, w_rd_next;
  logic        w_go, w_same_set;

  assign w_go       = (r_state == IDLE) && !flush;
  assign w_same_set = (hit_set == fill_set);

  // The hit instance also absorbs a same-set fill so both merge into one write.
  lfu_set_update u_hit (
    .cur      (r_counts[hit_set]),
    .hit_en   (hit_valid),
    .hit_way  (hit_way),
    .fill_en  (fill_valid && w_same_set),
    .fill_way (fill_way),
    .nxt      (w_hit_next)
  );

  lfu_set_update u_fill (
    .cur      (r_counts[fill_set]),
    .hit_en   (1'b0),
    .hit_way  (hit_way),
    .fill_en  (fill_valid),
    .fill_way (fill_way),
    .nxt      (w_fill_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < numSets; s++) begin
        r_counts[s] <= '0;
      end
    end else if (r_state == FLUSH) begin
      r_counts[r_flush_idx] <= '0;
    end else if (w_go) begin
      if (hit_valid) begin
        r_counts[hit_set] <= w_hit_next;
      end
      if (fill_valid && !(hit_valid && w_same_set)) begin
        r_counts[fill_set] <= w_fill_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_flush_idx <= '0;
    end else begin
      r_state     <= w_state_next;
      r_flush_idx <= (r_state == FLUSH) ? r_flush_idx + 1'b1 : '0;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (flush) w_state_next = FLUSH;
      FLUSH:   if (r_flush_idx == SET_W'(numSets - 1)) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == FLUSH);
  end

  // Write-first read: forward this cycle's update when the read set matches.
  always_comb begin
    w_rd_next = r_counts[rd_set];
    if (hit_valid && (rd_set == hit_set)) begin
      w_rd_next = w_hit_next;
    end else if (fill_valid && (rd_set == fill_set)) begin
      w_rd_next = w_fill_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_valid <= 1'b0;
      r_rd_counts <= '0;
    end else begin
      r_cnt_valid <= w_go && rd_valid;
      if (w_go && rd_valid) begin
        r_rd_counts <= w_rd_next;
      end
    end
  end

  assign cnt_valid = r_cnt_valid;
  assign count0    = r_rd_counts[0];
  assign count1    = r_rd_counts[1];
  assign count2    = r_rd_counts[2];
  assign count3    = r_rd_counts[3];

endmodule
`default_nettype wire

// File: tb/tb_lfu_counter_bank.sv
`default_nettype none
// ============================================================================
// tb_lfu_counter_bank : vector table plus read scoreboard for lfu_counter_bank
// Revision: 1.0 - initial release
// ============================================================================
module tb_lfu_counter_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hit_valid = 1'b0, fill_valid = 1'b0, rd_valid = 1'b0, flush = 1'b0;
  logic [3:0] hit_set = '0, fill_set = '0, rd_set = '0;
  logic [1:0] hit_way = '0, fill_way = '0;
  logic       busy, cnt_valid;
  logic [3:0] count0, count1, count2, count3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int         rep;
    logic       hv;  logic [3:0] hs; logic [1:0] hw;
    logic       fv;  logic [3:0] fs; logic [1:0] fw;
    logic       rv;  logic [3:0] rs;
    logic [15:0] exp;   // {count3,count2,count1,count0}
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] sb[$];
  logic [15:0] last_exp = '0;

  lfu_counter_bank #(.sizeCounter(4), .numSets(16)) dut (
    .clk(clk), .rst(rst),
    .hit_valid(hit_valid), .hit_set(hit_set), .hit_way(hit_way),
    .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way),
    .rd_valid(rd_valid), .rd_set(rd_set), .flush(flush),
    .busy(busy), .cnt_valid(cnt_valid),
    .count0(count0), .count1(count1), .count2(count2), .count3(count3)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(input int rep,
                              input logic hv, input logic [3:0] hs, input logic [1:0] hw,
                              input logic fv, input logic [3:0] fs, input logic [1:0] fw,
                              input logic rv, input logic [3:0] rs, input logic [15:0] exp);
    vec_t v;
    v.rep = rep; v.hv = hv; v.hs = hs; v.hw = hw;
    v.fv = fv; v.fs = fs; v.fw = fw; v.rv = rv; v.rs = rs; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic step(input vec_t v, input logic fl, input logic cv);
    logic [15:0] e;
    hit_valid = v.hv; hit_set = v.hs; hit_way = v.hw;
    fill_valid = v.fv; fill_set = v.fs; fill_way = v.fw;
    rd_valid = v.rv; rd_set = v.rs; flush = fl;
    if (cv) sb.push_back(v.exp);
    @(posedge clk);
    #1;
    hit_valid = 1'b0; fill_valid = 1'b0; rd_valid = 1'b0; flush = 1'b0;
    check("cnt_valid", {31'd0, cnt_valid}, {31'd0, cv});
    if (cv && sb.size() > 0) begin
      e = sb.pop_front();
      last_exp = e;
      check($sformatf("counts set %0d", v.rs), {16'd0, count3, count2, count1, count0}, {16'd0, e});
    end else begin
      check("counts hold", {16'd0, count3, count2, count1, count0}, {16'd0, last_exp});
    end
  endtask

  vec_t idle;

  initial begin
    idle = mk(1, 0,0,0, 0,0,0, 0,0, 16'h0000);

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 0);
    check("reset cnt_valid", {31'd0, cnt_valid}, 0);
    check("reset counts", {16'd0, count3, count2, count1, count0}, 0);
    rst = 1'b0;

    // set 2: fill then three hits
    tbl.push_back(mk(1, 0,0,0, 1,2,1, 0,0, 16'h0000));
    tbl.push_back(mk(3, 1,2,1, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,2, 16'h0040));
    // set 5: build {3,6,15,8}, then age on saturation
    tbl.push_back(mk(1, 0,0,0, 1,5,0, 0,0, 16'h0000));
    tbl.push_back(mk(2, 1,5,0, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 1,5,1, 0,0, 16'h0000));
    tbl.push_back(mk(5, 1,5,1, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 1,5,2, 0,0, 16'h0000));
    tbl.push_back(mk(14,1,5,2, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 1,5,3, 0,0, 16'h0000));
    tbl.push_back(mk(7, 1,5,3, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,5, 16'h8F63));
    tbl.push_back(mk(1, 1,5,2, 0,0,0, 1,5, 16'h4831));
    tbl.push_back(mk(1, 1,5,2, 0,0,0, 1,5, 16'h4931));
    // set 7: hit+fill same way, then hit+fill different ways
    tbl.push_back(mk(1, 0,0,0, 1,7,0, 0,0, 16'h0000));
    tbl.push_back(mk(8, 1,7,0, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,7, 16'h0009));
    tbl.push_back(mk(1, 1,7,0, 1,7,0, 1,7, 16'h0001));
    tbl.push_back(mk(1, 0,0,0, 1,7,1, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 1,7,2, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 1,7,3, 0,0, 16'h0000));
    tbl.push_back(mk(1, 1,7,1, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 1,7,2, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 1,7,3, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(3, 1,7,0, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,7, 16'h2224));
    tbl.push_back(mk(1, 1,7,0, 1,7,3, 1,7, 16'h1225));
    // set 9: aging hit with a fill of another way in the same cycle
    tbl.push_back(mk(1, 0,0,0, 1,9,0, 0,0, 16'h0000));
    tbl.push_back(mk(14,1,9,0, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 0,0,0, 1,9,1, 0,0, 16'h0000));
    tbl.push_back(mk(3, 1,9,1, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 1,9,0, 1,9,1, 1,9, 16'h0018));
    // set 1: write-first read
    tbl.push_back(mk(1, 0,0,0, 1,1,3, 0,0, 16'h0000));
    tbl.push_back(mk(1, 1,1,3, 0,0,0, 0,0, 16'h0000));
    tbl.push_back(mk(1, 1,1,3, 0,0,0, 1,1, 16'h3000));
    // different sets in one cycle
    tbl.push_back(mk(1, 1,2,1, 1,4,0, 1,4, 16'h0001));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 1,2, 16'h0050));
    tbl.push_back(mk(1, 1,4,0, 1,2,1, 1,2, 16'h0010));
    tbl.push_back(mk(1, 0,0,0, 0,0,0, 0,0, 16'h0000));

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].rep; r++) begin
        step(tbl[i], 1'b0, tbl[i].rv);
      end
    end

    // flush with same-cycle hit/read (dropped), then 16 busy cycles of ignored traffic
    step(mk(1, 1,5,0, 0,0,0, 1,5, 16'h0000), 1'b1, 1'b0);
    check("busy start", {31'd0, busy}, 1);
    for (int i = 0; i < 15; i++) begin
      step(mk(1, 1,0,0, 1,0,1, 1,0, 16'h0000), 1'b1, 1'b0);
      check($sformatf("busy cycle %0d", i + 2), {31'd0, busy}, 1);
    end
    step(idle, 1'b0, 1'b0);
    check("busy end", {31'd0, busy}, 0);
    step(mk(1, 0,0,0, 0,0,0, 1,0, 16'h0000), 1'b0, 1'b1);
    step(mk(1, 0,0,0, 0,0,0, 1,5, 16'h0000), 1'b0, 1'b1);
    step(mk(1, 0,0,0, 0,0,0, 1,7, 16'h0000), 1'b0, 1'b1);
    step(mk(1, 0,0,0, 0,0,0, 1,9, 16'h0000), 1'b0, 1'b1);

    // reset in the fifth flush cycle
    step(mk(1, 0,0,0, 1,12,2, 0,0, 16'h0000), 1'b0, 1'b0);
    step(mk(1, 0,0,0, 1,3,1,  1,12, 16'h0100), 1'b0, 1'b1);
    step(idle, 1'b1, 1'b0);
    repeat (4) step(idle, 1'b0, 1'b0);
    check("mid-flush busy", {31'd0, busy}, 1);
    #3 rst = 1'b1;
    #1;
    check("async reset busy", {31'd0, busy}, 0);
    check("async reset cnt_valid", {31'd0, cnt_valid}, 0);
    check("async reset counts", {16'd0, count3, count2, count1, count0}, 0);
    last_exp = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(mk(1, 0,0,0, 0,0,0, 1,3,  16'h0000), 1'b0, 1'b1);
    step(mk(1, 0,0,0, 0,0,0, 1,12, 16'h0000), 1'b0, 1'b1);
    check("post-reset idle", {31'd0, busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
